cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller for one core port.
- Sequences a single cache_sram instance that holds tag and data per line.
- Sits between the core load/store port and the memory bus; misses are filled from memory one word at a time.
- Per-line valid bits live in resettable flops, because the SRAM has no reset.

Parameters:
- ADDR_W, 30, word-address width of the core and memory ports.
- DATA_W, 32, data word width.
- IDX_W, 6, index width; the cache has 2**IDX_W lines of one word each. TAG_W = ADDR_W - IDX_W.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pulse: invalidate all lines.
- core_req  in  1  request valid; held high until core_ready.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  word address.
- core_wdata  in  DATA_W  store data.
- core_ready  out  1  one-cycle completion pulse.
- core_rdata  out  DATA_W  load data; valid while core_ready = 1.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data; valid with mem_ack.

Behaviour:
- Reset values: state IDLE, all valid = 0, and every output 0 (core_ready, core_rdata, mem_req, mem_we, mem_addr, mem_wdata).
- Address split: index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W].
- SRAM word layout is {tag, data}. SRAM read latency is 1 cycle; read-during-write to the same address returns old data.
- IDLE:
  - flush has priority: clear all valid bits that cycle, ignore core_req, stay in IDLE.
  - Else on core_req: latch addr, we and wdata; drive SRAM rdaddress = index; go to LOOKUP.
- LOOKUP: hit = valid[idx] and (q.tag == latched tag).
  - Load hit: core_ready = 1, core_rdata = q.data; go to IDLE. Total latency is 2 cycles from acceptance.
  - Load miss: go to FILL.
  - Store hit: write {tag, wdata} to SRAM this cycle; go to WRITE.
  - Store miss: go to WRITE with no SRAM update.
- FILL:
  - mem_req = 1, mem_we = 0, mem_addr = latched addr, held stable until mem_ack.
  - On mem_ack: write {tag, mem_rdata} to SRAM, set valid[idx], register mem_rdata; go to RESP.
- RESP: core_ready = 1, core_rdata = registered fill data; go to IDLE.
- WRITE:
  - mem_req = 1, mem_we = 1, mem_addr = latched addr, mem_wdata = latched wdata.
  - On mem_ack: core_ready = 1; go to IDLE.
- mem_req drops the cycle after mem_ack. mem_ack outside FILL or WRITE is ignored.
- Back-to-back requests: the earliest next acceptance is the cycle after core_ready. Fill and store-hit writes always complete before the next SRAM read, so there is no read-during-write hazard.
- flush arriving outside IDLE is dropped. The core must re-pulse it in IDLE.
- core_rdata holds its last value when core_ready = 0.
- Reset mid-operation: return to IDLE immediately, clear valid, drop mem_req. The in-flight memory transaction is abandoned and SRAM contents are stale but invalid.

Decomposition:
- Package cache_pkg holds:
  - state enum {IDLE, LOOKUP, FILL, RESP, WRITE};
  - function-derived TAG_W;
  - line_t packed struct {tag, data}.
- One sub-module: cache_sram with width = TAG_W + DATA_W and widthad = IDX_W. Valid array and FSM stay in cache_ctrl.

Test Plan:
- Cold load 0x010 with memory returning 0xDEADBEEF after 3 cycles -> mem_req with mem_addr = 0x010, mem_we = 0; core_ready with rdata 0xDEADBEEF; a repeat load of 0x010 gives core_ready 2 cycles after acceptance with no mem_req.
- Conflict: load 0x010, then load 0x050 (same index 0x10, tag 1) -> second access misses; a third load of 0x010 misses again.
- Store hit: after the 0x010 fill, store 0x12345678 to 0x010 -> mem write of 0x12345678; a following load of 0x010 hits and returns 0x12345678 with no mem_req.
- Store miss to 0x020 -> mem write only; a following load of 0x020 misses.
- flush after filling 0x010 and 0x011 -> both subsequent loads miss; flush asserted during FILL has no effect.
- rst_n low for 1 cycle while in FILL with mem_req = 1 -> all outputs 0 and state IDLE; after reset, a load of 0x010 misses.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped write-through cache.
// Holds the FSM state enum, the derived tag width and the SRAM line layout.
package cache_pkg;

  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 6;

  function automatic int tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w;
  endfunction

  localparam int TAG_W = tag_w(DEF_ADDR_W, DEF_IDX_W);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    FILL,
    RESP,
    WRITE
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [DEF_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/cache_sram.sv
// Simple dual-port SRAM, 1-cycle registered read, old data on read-during-write.
// Ports: clk, wren/wraddress/data (write), rdaddress/q (read). No reset.
module cache_sram #(
  parameter int WIDTH   = 56,
  parameter int WIDTHAD = 6
) (
  input  logic               clk,
  input  logic               wren,
  input  logic [WIDTHAD-1:0] wraddress,
  input  logic [WIDTH-1:0]   data,
  input  logic [WIDTHAD-1:0] rdaddress,
  output logic [WIDTH-1:0]   q
);

  logic [WIDTH-1:0] mem [2**WIDTHAD];

  always_ff @(posedge clk) begin
    if (wren) mem[wraddress] <= data;
    q <= mem[rdaddress];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// Ports: flush, core_* load/store port, mem_* word bus; outputs registered.
module cache_ctrl #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  output logic [DATA_W-1:0] core_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  import cache_pkg::*;

  localparam int LINES = 2**IDX_W;
  localparam int LW    = TAG_W + DATA_W;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] fill_q;

  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  rd_idx;
  logic [LW-1:0]     q_raw;
  line_t             q_line;
  line_t             wr_line;
  logic              sram_we;
  logic              hit;

  assign idx_q  = addr_q[IDX_W-1:0];
  assign tag_q  = addr_q[ADDR_W-1:IDX_W];
  // Look up straight from the core address so q is ready in LOOKUP.
  assign rd_idx = (state == IDLE) ? core_addr[IDX_W-1:0] : idx_q;
  assign q_line = line_t'(q_raw);
  assign hit    = valid[idx_q] && (q_line.tag == tag_q);

  always_comb begin
    sram_we      = 1'b0;
    wr_line      = '0;
    wr_line.tag  = tag_q;
    wr_line.data = wdata_q;
    if (state == FILL && mem_ack) begin
      sram_we      = 1'b1;
      wr_line.data = mem_rdata;
    end else if (state == LOOKUP && we_q && hit) begin
      sram_we = 1'b1;
    end
  end

  cache_sram #(
    .WIDTH   (LW),
    .WIDTHAD (IDX_W)
  ) u_sram (
    .clk       (clk),
    .wren      (sram_we),
    .wraddress (idx_q),
    .data      (wr_line),
    .rdaddress (rd_idx),
    .q         (q_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      fill_q     <= '0;
      core_ready <= 1'b0;
      core_rdata <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      core_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          // core_ready still high means the core has not yet
          // dropped the request it just got an answer for.
          if (flush) begin
            valid <= '0;
          end else if (core_req && !core_ready) begin
            addr_q  <= core_addr;
            we_q    <= core_we;
            wdata_q <= core_wdata;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_q && hit) begin
            core_ready <= 1'b1;
            core_rdata <= q_line.data;
            state      <= IDLE;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= we_q;
            mem_addr <= addr_q;
            if (we_q) mem_wdata <= wdata_q;
            state <= we_q ? WRITE : FILL;
          end
        end
        FILL: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            valid[idx_q] <= 1'b1;
            fill_q       <= mem_rdata;
            state        <= RESP;
          end
        end
        RESP: begin
          core_ready <= 1'b1;
          core_rdata <= fill_q;
          state      <= IDLE;
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            core_ready <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
